// File: rtl/wca_rf_seq.sv
// wca_rf_seq: ordered RF front-end power-up/power-down sequencer
module wca_rf_seq #(
  parameter int CNT_W = 16,
  parameter int CAL_LEN = 1024,
  parameter int DIS_DLY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req_rx1,
  input  logic             req_rx2,
  input  logic             req_tx1,
  input  logic [CNT_W-1:0] clk_settle,
  input  logic [CNT_W-1:0] en_settle,
  output logic             rxclk_en,
  output logic             txclk_en,
  output logic             rf1_rxen,
  output logic             rf1_txen,
  output logic             rf2_rxen,
  output logic             dc_clear,
  output logic             rx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {IDLE, CLK_ON, EN_ON, CAL, RUN, DIS_EN, CLK_OFF} state_t;
  localparam logic [CNT_W-1:0] CAL_INIT = CNT_W'(CAL_LEN - 1);
  localparam logic [CNT_W-1:0] DIS_INIT = CNT_W'(DIS_DLY - 1);
  state_t cur, nxt;
  logic [2:0] cfg, cfg_nxt, req;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic clk_on, en_on, run;
  assign req = {req_tx1, req_rx2, req_rx1};
  assign state = cur;
  always_comb begin
    nxt = cur;
    cfg_nxt = cfg;
    cnt_nxt = cnt - CNT_W'(1);
    if (!enable) begin
      nxt = IDLE;
      cfg_nxt = '0;
      cnt_nxt = '0;
    end else begin
      case (cur)
        IDLE: begin
          cnt_nxt = cnt;
          if (req != '0) begin
            nxt = CLK_ON;
            cfg_nxt = req;
            cnt_nxt = clk_settle;
          end
        end
        CLK_ON: if (req != cfg) begin
          nxt = DIS_EN;
          cnt_nxt = DIS_INIT;
        end else if (cnt == '0) begin
          nxt = EN_ON;
          cnt_nxt = en_settle;
        end
        EN_ON: if (req != cfg) begin
          nxt = DIS_EN;
          cnt_nxt = DIS_INIT;
        end else if (cnt == '0) begin
          nxt = CAL;
          cnt_nxt = CAL_INIT;
        end
        CAL: if (req != cfg) begin
          nxt = DIS_EN;
          cnt_nxt = DIS_INIT;
        end else if (cnt == '0) begin
          nxt = RUN;
        end
        RUN: if (req != cfg) begin
          nxt = DIS_EN;
          cnt_nxt = DIS_INIT;
        end else begin
          cnt_nxt = cnt;
        end
        DIS_EN: if (cnt == '0) begin
          nxt = CLK_OFF;
          cnt_nxt = DIS_INIT;
        end
        CLK_OFF: if (cnt == '0) begin
          nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
    clk_on = nxt == CLK_ON || nxt == EN_ON || nxt == CAL || nxt == RUN || nxt == DIS_EN;
    en_on = nxt == EN_ON || nxt == CAL || nxt == RUN;
    run = nxt == RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= IDLE;
      cfg <= '0;
      cnt <= '0;
      rxclk_en <= 1'b0;
      txclk_en <= 1'b0;
      rf1_rxen <= 1'b0;
      rf1_txen <= 1'b0;
      rf2_rxen <= 1'b0;
      dc_clear <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      cur <= nxt;
      cfg <= cfg_nxt;
      cnt <= cnt_nxt;
      rxclk_en <= clk_on & (cfg_nxt[0] | cfg_nxt[1]);
      txclk_en <= clk_on & cfg_nxt[2];
      rf1_rxen <= en_on & cfg_nxt[0];
      rf2_rxen <= en_on & cfg_nxt[1];
      rf1_txen <= en_on & cfg_nxt[2];
      dc_clear <= nxt == CAL && cur != CAL;
      rx_valid <= run & (cfg_nxt[0] | cfg_nxt[1]);
      tx_ready <= run & cfg_nxt[2];
      busy <= nxt != IDLE && nxt != RUN;
    end
  end
endmodule

// File: tb/tb_wca_rf_seq.sv
// tb_wca_rf_seq: directed self-checking bench for wca_rf_seq
module tb_wca_rf_seq;
  logic clock = 1'b0;
  logic reset, enable, req_rx1, req_rx2, req_tx1;
  logic [15:0] clk_settle, en_settle;
  logic rxclk_en, txclk_en, rf1_rxen, rf1_txen, rf2_rxen, dc_clear, rx_valid, tx_ready, busy;
  logic [2:0] state;
  logic [11:0] outs;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  wca_rf_seq #(.CNT_W(16), .CAL_LEN(8), .DIS_DLY(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req_rx1(req_rx1), .req_rx2(req_rx2), .req_tx1(req_tx1),
    .clk_settle(clk_settle), .en_settle(en_settle),
    .rxclk_en(rxclk_en), .txclk_en(txclk_en), .rf1_rxen(rf1_rxen), .rf1_txen(rf1_txen),
    .rf2_rxen(rf2_rxen), .dc_clear(dc_clear), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .busy(busy), .state(state)
  );
  assign outs = {rxclk_en, txclk_en, rf1_rxen, rf1_txen, rf2_rxen, dc_clear, rx_valid, tx_ready, busy, state};
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [11:0] exp);
    n_chk++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; enable = 1'b0; req_rx1 = 1'b0; req_rx2 = 1'b0; req_tx1 = 1'b0;
    clk_settle = 16'd3; en_settle = 16'd5;
    tick(2);
    chk("reset", 12'b00000_000_0_000);
    reset = 1'b0; enable = 1'b1;
    tick();
    chk("idle_noreq", 12'b00000_000_0_000);
    req_rx1 = 1'b1;
    tick();
    chk("clk_on_rx1", 12'b10000_000_1_001);
    tick(3);
    chk("clk_on_last", 12'b10000_000_1_001);
    tick();
    chk("en_on_rx1", 12'b10100_000_1_010);
    tick(5);
    chk("en_on_last", 12'b10100_000_1_010);
    tick();
    chk("cal_dc", 12'b10100_100_1_011);
    tick();
    chk("cal_nodc", 12'b10100_000_1_011);
    tick(6);
    chk("cal_last", 12'b10100_000_1_011);
    tick();
    chk("run_rx1", 12'b10100_010_0_100);
    tick();
    chk("run_hold", 12'b10100_010_0_100);
    req_tx1 = 1'b1;
    tick();
    chk("dis_en", 12'b10000_000_1_101);
    tick(3);
    chk("dis_en_last", 12'b10000_000_1_101);
    tick();
    chk("clk_off", 12'b00000_000_1_110);
    tick(3);
    chk("clk_off_last", 12'b00000_000_1_110);
    tick();
    chk("idle_return", 12'b00000_000_0_000);
    tick();
    chk("clk_on_101", 12'b11000_000_1_001);
    tick(4);
    chk("en_on_101", 12'b11110_000_1_010);
    enable = 1'b0;
    tick();
    chk("abort", 12'b00000_000_0_000);
    tick();
    chk("abort_no_dc", 12'b00000_000_0_000);
    enable = 1'b1; clk_settle = 16'd0; en_settle = 16'd0;
    req_rx1 = 1'b0; req_tx1 = 1'b0; req_rx2 = 1'b1;
    tick();
    chk("zero_clk_on", 12'b10000_000_1_001);
    tick();
    chk("zero_en_on", 12'b10001_000_1_010);
    tick();
    chk("zero_cal", 12'b10001_100_1_011);
    enable = 1'b0;
    tick();
    chk("abort_cal", 12'b00000_000_0_000);
    enable = 1'b1; clk_settle = 16'd2; en_settle = 16'd1;
    req_rx1 = 1'b1; req_rx2 = 1'b0;
    tick();
    chk("sim_clk_on", 12'b10000_000_1_001);
    tick(2);
    chk("sim_clk_on_last", 12'b10000_000_1_001);
    req_rx2 = 1'b1;
    tick();
    chk("sim_dis_en", 12'b10000_000_1_101);
    tick(4);
    chk("sim_clk_off", 12'b00000_000_1_110);
    tick(4);
    chk("sim_idle", 12'b00000_000_0_000);
    tick();
    chk("rx12_clk_on", 12'b10000_000_1_001);
    tick(3);
    chk("rx12_en_on", 12'b10101_000_1_010);
    tick(2);
    chk("rx12_cal_dc", 12'b10101_100_1_011);
    tick();
    chk("rx12_cal", 12'b10101_000_1_011);
    reset = 1'b1;
    tick();
    chk("reset_mid_cal", 12'b00000_000_0_000);
    reset = 1'b0;
    tick();
    chk("restart_clk_on", 12'b10000_000_1_001);
    tick(3);
    chk("restart_en_on", 12'b10101_000_1_010);
    tick(2);
    chk("restart_cal_dc", 12'b10101_100_1_011);
    tick(8);
    chk("restart_run", 12'b10101_010_0_100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
